mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer for the single-port 16x128 memory.
//  Muxes one read or write per cycle onto the shared addr/w_data/w_en/r_en port.
//  Returns read data to the issuing requester one cycle after acceptance.
//  Sequences a full-memory clear through the memory's synchronous rst input.
// PARAMETERS
//  WIDTH       16   data width; must match memory WIDTH
//  ADDR_WIDTH  7    address width; must match memory ADDR_WIDTH
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           asynchronous, active-high reset
//  req0_valid   in   1           requester 0 has an op pending; held until accepted
//  req0_we      in   1           1=write, 0=read
//  req0_addr    in   ADDR_WIDTH  op address
//  req0_wdata   in   WIDTH       write data (ignored for reads)
//  req0_ready   out  1           op accepted this cycle (valid & ready = transfer)
//  rsp0_valid   out  1           read data for requester 0 valid this cycle
//  rsp0_rdata   out  WIDTH       read data for requester 0
//  req1_*/rsp1_*    same set as requester 0, for requester 1
//  clr_req      in   1           single-cycle pulse: request full-memory clear
//  clr_busy     out  1           clear in progress (state CLEAR)
//  mem_rst      out  1           to memory rst
//  mem_addr     out  ADDR_WIDTH  to memory addr
//  mem_w_data   out  WIDTH       to memory w_data
//  mem_w_en     out  1           to memory w_en
//  mem_r_en     out  1           to memory r_en
//  mem_r_data   in   WIDTH       from memory r_data (registered in memory)
// BEHAVIOUR
//  Reset (async, rst=1): state=RUN, rr_ptr=0 (req0 has priority), rsp tag cleared.
//   rsp0/1_valid=0, rsp0/1_rdata=0, req0/1_ready=0, mem_w_en=mem_r_en=mem_rst=0,
//   clr_busy=0.
//  FSM: RUN -> CLEAR when clr_req=1 sampled in RUN; CLEAR -> RUN unconditionally
//   after 1 cycle. clr_req ignored in CLEAR.
//  CLEAR cycle: mem_rst=1, clr_busy=1, req0/1_ready=0, mem_w_en=mem_r_en=0.
//  RUN grant (combinational): grant only a valid requester.
//   If both valid, grant the one selected by rr_ptr.
//   If exactly one is valid, grant it regardless of rr_ptr.
//  Grant in the cycle clr_req rises is allowed; the clear follows next cycle.
//  req*_ready may depend on req*_valid; requesters must not make valid depend on ready.
//  rr_ptr update: on a grant, rr_ptr <= other requester; else unchanged.
//   Both continuously valid -> strict alternation 0,1,0,1...
//  Memory drive: mem_addr/mem_w_data = granted request fields; mem_w_en = grant & we;
//   mem_r_en = grant & ~we. No grant: enables 0, addr/w_data = req0 fields.
//  Read latency: accepted read in cycle t -> rspN_valid=1 in cycle t+1, rspN_rdata=
//   mem_r_data (registered tag selects N; other rsp valid=0, rdata holds last value).
//  Exactly one op per cycle; back-to-back reads pipeline at 1 op/cycle.
//  Read whose response cycle coincides with CLEAR still returns pre-clear data
//   (memory clears at the end of the CLEAR cycle).
//  Writes produce no response. Read after write to the same address in the next
//   cycle returns the new data.
//  Reset mid-operation: pending response dropped (rsp valid forced 0); clear aborted.
//  Address width is passed through unchanged; no range checking (2^ADDR_WIDTH = DEPTH).
// TESTING
//  1 Reset release with no valid -> all enables 0, rsp valid 0, rr_ptr=0.
//  2 req0 write addr 5 data 16'hA5A5, then req0 read addr 5 -> rsp0_valid 1 cycle
//    after accept with rdata 16'hA5A5; rsp1_valid stays 0.
//  3 req0 and req1 both hold valid reads (addr 1, 2) for 4 cycles ->
//    grants 0,1,0,1; responses alternate with correct data.
//  4 req1 alone issues 3 back-to-back reads -> 3 consecutive grants and 3 consecutive
//    rsp1_valid cycles.
//  5 Write addr 9 = 16'h1234, pulse clr_req while req0 reads addr 9 ->
//    read returns 16'h1234. CLEAR: 1 cycle, ready=0, mem_rst=1. A later read of
//    addr 9 returns 0.
//  6 Assert rst the cycle after a read is accepted -> rsp valid 0 immediately;
//    rr_ptr=0 after release.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port memory,
// with a one-cycle full-memory clear sequenced through the memory reset.
module mem_rr_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [WIDTH-1:0]      rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [WIDTH-1:0]      rsp1_rdata,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  mem_rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_w_data,
  output logic                  mem_w_en,
  output logic                  mem_r_en,
  input  logic [WIDTH-1:0]      mem_r_data
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             rr_ptr;
  logic             rsp_pend;
  logic             rsp_tag;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] hold0;
  logic [WIDTH-1:0] hold1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:   if (clr_req) state_nx = CLEAR;
      CLEAR: state_nx = RUN;
    endcase
  end

  // rr_ptr only breaks ties; a lone valid requester always wins
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    clr_busy = 1'b0;
    mem_rst  = 1'b0;
    unique case (state)
      RUN: begin
        gnt0 = ~rst & req0_valid & (~req1_valid | ~rr_ptr);
        gnt1 = ~rst & req1_valid & (~req0_valid | rr_ptr);
      end
      CLEAR: begin
        clr_busy = 1'b1;
        mem_rst  = 1'b1;
      end
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign mem_addr   = gnt1 ? req1_addr  : req0_addr;
  assign mem_w_data = gnt1 ? req1_wdata : req0_wdata;
  assign mem_w_en   = (gnt0 & req0_we) | (gnt1 & req1_we);
  assign mem_r_en   = (gnt0 & ~req0_we) | (gnt1 & ~req1_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      rsp_pend <= 1'b0;
      rsp_tag  <= 1'b0;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      if (gnt0)      rr_ptr <= 1'b1;
      else if (gnt1) rr_ptr <= 1'b0;
      rsp_pend <= mem_r_en;
      rsp_tag  <= gnt1;
      if (rsp0_valid) hold0 <= mem_r_data;
      if (rsp1_valid) hold1 <= mem_r_data;
    end
  end

  // memory registers its read data, so the response lands one cycle later
  assign rsp0_valid = rsp_pend & ~rsp_tag;
  assign rsp1_valid = rsp_pend & rsp_tag;
  assign rsp0_rdata = rsp0_valid ? mem_r_data : hold0;
  assign rsp1_rdata = rsp1_valid ? mem_r_data : hold1;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: behavioural memory plus a reference model
// of arbitration, memory contents and response timing.
module tb_mem_rr_arbiter;

  localparam int W  = 16;
  localparam int AW = 7;
  localparam int D  = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 0, req0_we = 0;
  logic [AW-1:0] req0_addr = '0;
  logic [W-1:0]  req0_wdata = '0;
  logic          req1_valid = 0, req1_we = 0;
  logic [AW-1:0] req1_addr = '0;
  logic [W-1:0]  req1_wdata = '0;
  logic          clr_req = 1'b0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [W-1:0]  rsp0_rdata, rsp1_rdata;
  logic          clr_busy, mem_rst, mem_w_en, mem_r_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_w_data, mem_r_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .mem_rst(mem_rst),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_r_data(mem_r_data)
  );

  // single-port memory with synchronous clear and registered read
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      mem_r_data <= '0;
    end else begin
      if (mem_w_en) mem[mem_addr] <= mem_w_data;
      if (mem_r_en) mem_r_data <= mem[mem_addr];
    end
  end

  // reference model
  int           m_turn;
  bit           m_clear;
  int           m_who;
  logic [W-1:0] m_data, m_last0, m_last1;
  logic [W-1:0] m_mem [D];

  function automatic int exp_grant();
    if (rst || m_clear) return -1;
    if (req0_valid && req1_valid) return m_turn;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic sel_we();
    return (exp_grant() == 1) ? req1_we : req0_we;
  endfunction

  function automatic logic [AW-1:0] sel_addr();
    return (exp_grant() == 1) ? req1_addr : req0_addr;
  endfunction

  function automatic logic [W-1:0] sel_wdata();
    return (exp_grant() == 1) ? req1_wdata : req0_wdata;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_turn  <= 0;
      m_clear <= 0;
      m_who   <= -1;
      m_last0 <= '0;
      m_last1 <= '0;
    end else begin
      if (m_who == 0) m_last0 <= m_data;
      if (m_who == 1) m_last1 <= m_data;
      m_who <= -1;
      if (m_clear) begin
        for (int i = 0; i < D; i++) m_mem[i] <= '0;
        m_clear <= 0;
      end else begin
        m_clear <= clr_req;
        if (exp_grant() >= 0) begin
          m_turn <= 1 - exp_grant();
          if (sel_we()) m_mem[sel_addr()] <= sel_wdata();
          else begin
            m_who  <= exp_grant();
            m_data <= m_mem[sel_addr()];
          end
        end
      end
    end
  end

  function automatic logic [5:0] exp_ctl();
    int g;
    g = exp_grant();
    return {g == 0, g == 1, g >= 0 && sel_we(),
            g >= 0 && !sel_we(), m_clear, m_clear};
  endfunction

  function automatic logic [AW+W-1:0] exp_bus();
    return {sel_addr(), sel_wdata()};
  endfunction

  function automatic logic [2*W+1:0] exp_rsp();
    return {m_who == 0, m_who == 1,
            (m_who == 0) ? m_data : m_last0,
            (m_who == 1) ? m_data : m_last1};
  endfunction

  wire [5:0] act_ctl = {req0_ready, req1_ready, mem_w_en,
                        mem_r_en, mem_rst, clr_busy};
  wire [AW+W-1:0] act_bus = {mem_addr, mem_w_data};
  wire [2*W+1:0]  act_rsp = {rsp0_valid, rsp1_valid,
                             rsp0_rdata, rsp1_rdata};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic we,
                      input int a, input logic [W-1:0] d);
    req0_valid = v; req0_we = we;
    req0_addr = AW'(a); req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we,
                      input int a, input logic [W-1:0] d);
    req1_valid = v; req1_we = we;
    req1_addr = AW'(a); req1_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    set0(1, 0, 3, '0);
    #1;
    n_tests++;
    if (act_ctl !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b", act_ctl, 6'b0);
    end
    n_tests++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h want 0", act_rsp);
    end
    tick();
    set0(0, 0, 0, '0);
    rst = 1'b0;
    #1;
    n_tests++;
    if (act_ctl !== exp_ctl() || act_ctl !== 6'b0) begin
      n_fail++;
      $display("FAIL release_ctl: got %b want %b", act_ctl, 6'b0);
    end
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    n_tests++;
    if (act_ctl !== 6'b000011) begin
      n_fail++;
      $display("FAIL init_clear: got %b want %b", act_ctl, 6'b000011);
    end
    tick();
  endtask

  task automatic test_write_read();
    set0(1, 1, 5, 16'hA5A5);
    #1;
    n_tests++;
    if (act_ctl !== 6'b101000 || act_bus !== {7'd5, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL wr_issue: got %b/%h want 101000/05a5a5",
               act_ctl, act_bus);
    end
    tick();
    set0(1, 0, 5, '0);
    #1;
    n_tests++;
    if (act_ctl !== 6'b100100) begin
      n_fail++;
      $display("FAIL rd_issue: got %b want %b", act_ctl, 6'b100100);
    end
    tick();
    set0(0, 0, 0, '0);
    #1;
    n_tests++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 16'hA5A5}
        || act_rsp !== exp_rsp()) begin
      n_fail++;
      $display("FAIL rd_rsp: got %h want %h", act_rsp, exp_rsp());
    end
    tick();
  endtask

  task automatic test_alternation();
    do_reset();
    set0(1, 1, 1, 16'h1111);
    tick();
    set0(0, 0, 0, '0);
    set1(1, 1, 2, 16'h2222);
    tick();
    set0(1, 0, 1, '0);
    set1(1, 0, 2, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)
          || act_ctl !== exp_ctl()) begin
        n_fail++;
        $display("FAIL alt_grant%0d: got %b want %b",
                 i, act_ctl, exp_ctl());
      end
      if (i > 0) begin
        n_tests++;
        if (act_rsp !== exp_rsp() || (i % 2 == 1 ?
            {rsp0_valid, rsp0_rdata} !== {1'b1, 16'h1111} :
            {rsp1_valid, rsp1_rdata} !== {1'b1, 16'h2222})) begin
          n_fail++;
          $display("FAIL alt_rsp%0d: got %h want %h",
                   i, act_rsp, exp_rsp());
        end
      end
      tick();
    end
    set0(0, 0, 0, '0);
    set1(0, 0, 0, '0);
    #1;
    n_tests++;
    if ({rsp0_valid, rsp1_valid, rsp1_rdata} !== {2'b01, 16'h2222}) begin
      n_fail++;
      $display("FAIL alt_last: got %h want 1 on rsp1 with 2222", act_rsp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int addrs[3] = '{2, 1, 2};
    logic [W-1:0] vals[3] = '{16'h2222, 16'h1111, 16'h2222};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set1(1, 0, addrs[i], '0);
      else set1(0, 0, 0, '0);
      #1;
      if (i < 3) begin
        n_tests++;
        if (act_ctl !== 6'b010100 || mem_addr !== AW'(addrs[i])) begin
          n_fail++;
          $display("FAIL b2b_grant%0d: got %b want 010100", i, act_ctl);
        end
      end
      if (i > 0) begin
        n_tests++;
        if ({rsp0_valid, rsp1_valid, rsp1_rdata} !== {2'b01, vals[i-1]}
            || act_rsp !== exp_rsp()) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d: got %h want %h",
                   i, act_rsp, exp_rsp());
        end
      end
      tick();
    end
  endtask

  task automatic test_clear();
    set0(1, 1, 9, 16'h1234);
    tick();
    set0(1, 0, 9, '0);
    clr_req = 1'b1;
    #1;
    n_tests++;
    if (act_ctl !== 6'b100100) begin
      n_fail++;
      $display("FAIL clr_accept: got %b want 100100", act_ctl);
    end
    tick();
    clr_req = 1'b0;
    #1;
    n_tests++;
    if (act_ctl !== 6'b000011) begin
      n_fail++;
      $display("FAIL clr_cycle: got %b want 000011", act_ctl);
    end
    n_tests++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL clr_predata: got %b/%h want 1/1234",
               rsp0_valid, rsp0_rdata);
    end
    tick();
    #1;
    n_tests++;
    if (act_ctl !== 6'b100100) begin
      n_fail++;
      $display("FAIL clr_run: got %b want 100100", act_ctl);
    end
    tick();
    set0(0, 0, 0, '0);
    #1;
    n_tests++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL clr_postdata: got %b/%h want 1/0000",
               rsp0_valid, rsp0_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set1(1, 0, 4, '0);
    tick();
    set1(0, 0, 0, '0);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00 || act_ctl !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_rsp: got %b/%b want 00/000000",
               {rsp0_valid, rsp1_valid}, act_ctl);
    end
    tick();
    rst = 1'b0;
    set0(1, 0, 1, '0);
    set1(1, 0, 2, '0);
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_ptr: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    set0(0, 0, 0, '0);
    set1(0, 0, 0, '0);
    tick();
  endtask

  task automatic test_random();
    int g;
    bit ok;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0)
        set0(1, 1'($urandom), $urandom_range(0, 7), W'($urandom));
      if (!req1_valid && $urandom_range(0, 2) != 0)
        set1(1, 1'($urandom), $urandom_range(0, 7), W'($urandom));
      clr_req = (!clr_req && $urandom_range(0, 15) == 0);
      #1;
      ok = (act_ctl === exp_ctl()) && (act_bus === exp_bus())
           && (act_rsp === exp_rsp());
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand%0d: ctl %b/%b bus %h/%h rsp %h/%h", c,
                 act_ctl, exp_ctl(), act_bus, exp_bus(),
                 act_rsp, exp_rsp());
      end
      g = exp_grant();
      tick();
      if (g == 0) req0_valid = 1'b0;
      if (g == 1) req1_valid = 1'b0;
    end
    set0(0, 0, 0, '0);
    set1(0, 0, 0, '0);
    clr_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternation();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
